// File: rtl/input_debouncer_pkg.sv
// Shared constants and sizing helper for the I/O-conditioning blocks.
// Imported by the debouncer top and its per-bit slice.
package input_debouncer_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Counter must reach cycles-1. A one-cycle filter still needs one bit.
  function automatic int cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One debounced input bit: synchronizer chain, agreement counter,
// stable level flop and registered rise/fall pulses.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_d_o,
  output logic fall_d_o
);

  localparam int             CNT_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Any cycle of agreement restarts the count; acceptance also clears it.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_s != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_s;
        rise_d   = sync_s;
        fall_d   = ~sync_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign rise_d_o = rise_d;
  assign fall_d_o = fall_d;

endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH raw asynchronous pins into a clean synchronous bus,
// with per-bit edge pulses and a registered aggregate change strobe.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic [WIDTH-1:0] i_Raw,
  output logic [WIDTH-1:0] o_Stable,
  output logic [WIDTH-1:0] o_Rise,
  output logic [WIDTH-1:0] o_Fall,
  output logic             o_Changed
);

  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q, changed_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i   (i_Clock),
      .rst_n_i (i_Reset_n),
      .raw_i   (i_Raw[g]),
      .stable_o(o_Stable[g]),
      .rise_o  (o_Rise[g]),
      .fall_o  (o_Fall[g]),
      .rise_d_o(rise_d[g]),
      .fall_d_o(fall_d[g])
    );
  end

  // Built from next-state pulses so the strobe lands with the per-bit pulses.
  assign changed_d = |(rise_d | fall_d);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign o_Changed = changed_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized pin activity checked every cycle against a window-based model.
module tb_input_debouncer;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] stable, rise, fall;
  logic         changed;

  int compared   = 0;
  int mismatched = 0;

  input_debouncer #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .i_Raw    (raw),
    .o_Stable (stable),
    .o_Rise   (rise),
    .o_Fall   (fall),
    .o_Changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level is accepted at edge n when the synchronized value seen by
  // the last DC compare edges all differed from the accepted level and none
  // of those edges precede the previous acceptance of that bit.
  logic [W-1:0] hist[$];
  int           n;
  int           last_upd[W];
  logic [W-1:0] m_stable, m_rise, m_fall;
  logic         m_changed;

  task automatic model_reset();
    hist.delete();
    n = 0;
    for (int b = 0; b < W; b++) last_upd[b] = 0;
    m_stable  = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_changed = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] r);
    logic [W-1:0] h;
    bit ok;
    int j;
    hist.push_back(r);
    n++;
    m_rise    = '0;
    m_fall    = '0;
    m_changed = 1'b0;
    for (int b = 0; b < W; b++) begin
      ok = (n - last_upd[b] >= DC);
      for (int k = 0; k < DC; k++) begin
        j = n - SS - k;
        h = (j >= 1) ? hist[j-1] : '0;
        if (h[b] == m_stable[b]) ok = 0;
      end
      if (ok) begin
        m_stable[b] = ~m_stable[b];
        m_rise[b]   = m_stable[b];
        m_fall[b]   = ~m_stable[b];
        m_changed   = 1'b1;
        last_upd[b] = n;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step(raw);
    #1;
    chk("model", {changed, fall, rise, stable}, {m_changed, m_fall, m_rise, m_stable});
  end

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic settle(input logic [W-1:0] v);
    @(negedge clk);
    raw = v;
    edges(DC + SS + 2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_stable", stable, 4'b0000);
    chk("reset_changed", changed, 1'b0);
    rst_n = 1'b1;

    // Quiet inputs
    edges(40);
    chk("quiet_stable", stable, 4'b0000);

    // Single bit rise, exact latency
    @(negedge clk);
    raw = 4'b0001;
    edges(17);
    chk("rise0_pre_stable", stable, 4'b0000);
    edges(1);
    chk("rise0_stable", stable, 4'b0001);
    chk("rise0_rise", rise, 4'b0001);
    chk("rise0_changed", changed, 1'b1);
    edges(1);
    chk("rise0_rise_end", rise, 4'b0000);
    chk("rise0_changed_end", changed, 1'b0);

    // Bounce on bit 1: 10 high, 2 low, then held high
    @(negedge clk);
    raw = 4'b0011;
    repeat (10) @(negedge clk);
    raw = 4'b0001;
    repeat (2) @(negedge clk);
    raw = 4'b0011;
    edges(17);
    chk("bounce_pre_stable", stable, 4'b0001);
    edges(1);
    chk("bounce_stable", stable, 4'b0011);
    chk("bounce_rise", rise, 4'b0010);

    // Multi-bit simultaneous rise
    settle(4'b0000);
    chk("clear_stable", stable, 4'b0000);
    @(negedge clk);
    raw = 4'b1011;
    edges(17);
    chk("multi_pre_stable", stable, 4'b0000);
    edges(1);
    chk("multi_stable", stable, 4'b1011);
    chk("multi_rise", rise, 4'b1011);
    chk("multi_changed", changed, 1'b1);
    edges(1);
    chk("multi_changed_end", changed, 1'b0);

    // Fall on bit 2
    settle(4'b1111);
    @(negedge clk);
    raw = 4'b1011;
    edges(17);
    chk("fall2_pre_stable", stable, 4'b1111);
    edges(1);
    chk("fall2_stable", stable, 4'b1011);
    chk("fall2_fall", fall, 4'b0100);
    chk("fall2_rise", rise, 4'b0000);
    chk("fall2_changed", changed, 1'b1);

    // Reset mid-count on bit 3 while bit 0 is already stable high
    settle(4'b0001);
    @(negedge clk);
    raw = 4'b1001;
    edges(12);
    rst_n = 1'b0;
    #1;
    chk("rst_async_stable", stable, 4'b0000);
    chk("rst_async_pulses", {changed, fall, rise}, 9'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    edges(17);
    chk("rst_pre_stable", stable, 4'b0000);
    edges(1);
    chk("rst_stable", stable, 4'b1001);
    chk("rst_rise", rise, 4'b1001);

    // Randomized pin activity with occasional short glitches and resets
    for (int it = 0; it < 250; it++) begin
      int hold;
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) raw = raw ^ (4'b0001 << $urandom_range(0, W - 1));
      else                           raw = W'($urandom);
      hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(DC, DC + 12);
      repeat (hold - 1) @(negedge clk);
    end
    settle(raw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
